ddr_scheduler: RTL and testbench
================================

// Module: ddr_scheduler
// PURPOSE
//  Round-robin arbiter and command sequencer for the DDR datapath. Grants one of NREQ
//  requesters at a time and drives the datapath's ctl_* strobes (ACTIVE, READ/WRITE,
//  suspend) with fixed DDR timing. Also drives usr_owner and inserts periodic refresh.
// PARAMETERS
//  NREQ    4    number of requesters, 1..4 (owner id is 2 bits)
//  T_RCD   2    cycles from ctl_start_o pulse to READ/WRITE strobe, >=1
//  T_RP    2    precharge cycles after a transaction completes, >=1
//  T_REFI  780  cycles between refresh requests
//  T_RFC   8    cycles ctl_suspend_o is held for one refresh
// PORTS
//  clock_i        in   1     system clock, all logic on rising edge
//  reset_i        in   1     synchronous, active-high reset
//  req_i          in   NREQ  per-requester access request, level, held until gnt_o
//  req_write_i    in   NREQ  per-requester direction: 1=write, 0=read; valid with req_i
//  gnt_o          out  NREQ  one-hot grant, one-cycle pulse
//  usr_owner_o    out  2     owner id of the current transaction, to datapath
//  ctl_start_o    out  1     ACTIVE strobe, one cycle
//  ctl_block_o    out  1     high while a transaction owns the datapath
//  ctl_suspend_o  out  1     high during refresh
//  ctl_read_o     out  1     READ strobe, one cycle
//  ctl_write_o    out  1     WRITE strobe, one cycle
//  dp_ready_i     in   1     datapath usr_ready; marks the end of the data phase
//  busy_o         out  1     FSM not in IDLE
//  err_o          out  1     watchdog abort pulse (SCHED_WATCHDOG_EN only, else tied 0)
// BEHAVIOUR
//  Reset: every output is 0, state IDLE, RR pointer 0, refresh counter 0, no refresh pending.
//  FSM states and transitions:
//   IDLE: if refresh pending -> REFRESH. Else if any req_i -> ACTIVATE.
//     On entry to ACTIVATE: latch the winner's id and req_write_i, and pulse gnt_o.
//   ACTIVATE: 1 cycle; ctl_start_o=1 -> WAIT_RCD.
//   WAIT_RCD: T_RCD-1 cycles -> CMD. If T_RCD=1, go directly to CMD.
//   CMD: 1 cycle; ctl_write_o=1 if the latched direction is write, else ctl_read_o=1
//     -> WAIT_DATA.
//   WAIT_DATA: wait until dp_ready_i=1 -> PRECHARGE.
//     dp_ready_i in the CMD cycle itself is ignored.
//   PRECHARGE: T_RP cycles -> IDLE.
//   REFRESH: ctl_suspend_o=1 for exactly T_RFC cycles; clear pending -> IDLE.
//  Latency: ACTIVATE->CMD = T_RCD cycles. Minimum req_i-to-ctl_start_o = 1 cycle.
//  gnt_o: high in the same cycle the FSM enters ACTIVATE.
//   Requester drops req_i on the next cycle. A held req_i re-competes in the next IDLE.
//  Round robin: search begins at (last_owner+1) mod NREQ; the pointer updates on grant.
//   Bits of req_i at index >= NREQ are ignored.
//  usr_owner_o: updated at grant; held stable through PRECHARGE and in IDLE until the next grant.
//  ctl_block_o: 1 in ACTIVATE, WAIT_RCD, CMD and WAIT_DATA; 0 otherwise.
//  Refresh counter: free-running and never paused.
//   Wraps at T_REFI-1 and sets the pending flag at the wrap.
//   Refresh never preempts a transaction; it waits for IDLE.
//   A second wrap while already pending does not stack.
//  Simultaneous events: refresh pending and a request in the same IDLE cycle -> refresh first.
//  Reset mid-transaction: return to IDLE immediately with all strobes 0.
//   No PRECHARGE is issued; the datapath is reset alongside this block.
// CONFIGURATION
//  SCHED_WATCHDOG_EN defined: a 6-bit counter runs in WAIT_DATA.
//   If dp_ready_i has not arrived after 64 cycles: pulse err_o for 1 cycle, go to PRECHARGE.
//  SCHED_WATCHDOG_EN undefined: no counter; WAIT_DATA waits indefinitely; err_o tied 0.
// STRUCTURE
//  Package ddr_sched_pkg: FSM state enum (IDLE, ACTIVATE, WAIT_RCD, CMD, WAIT_DATA,
//   PRECHARGE, REFRESH), OWNER_W=2, watchdog limit constant 64.
//  Sub-module rr_arbiter (NREQ): request vector + pointer -> one-hot winner, id, valid.
//  Combinational only. Counters and FSM stay in ddr_scheduler.
// TESTING
//  1 Single read: req_i=4'b0010, rd, ready 3 cycles after CMD
//    -> gnt_o=0010, owner=1, start then read 2 cycles later, block 6 cycles, busy low after T_RP.
//  2 Round robin: req_i=4'b1011 held, re-asserted after each grant -> grant order 0,1,3,0,
//    usr_owner_o matches each grant.
//  3 Write direction: req_write_i[2]=1 with req_i[2] -> ctl_write_o pulse, no ctl_read_o,
//    exactly T_RCD cycles after ctl_start_o.
//  4 Refresh collision: T_REFI=20; request arrives on the wrap cycle -> suspend 8 cycles first,
//    then ACTIVATE; no strobe overlaps suspend.
//  5 Reset in WAIT_DATA -> next cycle all outputs 0, FSM IDLE, pointer back to 0.
//  6 SCHED_WATCHDOG_EN, dp_ready_i never asserted -> err_o pulse 64 cycles after CMD,
//    then PRECHARGE and IDLE. Without the macro: busy_o stays 1 forever.

Source files
------------

// File: rtl/ddr_sched_pkg.sv
// Shared types and constants for the DDR command scheduler: FSM states, owner-id width,
// watchdog limit and a one-hot decode helper.
package ddr_sched_pkg;

  localparam int unsigned OWNER_W  = 2;
  localparam int unsigned MAX_REQ  = 4;
  localparam int unsigned WD_LIMIT = 64;

  typedef enum logic [2:0] {
    StIdle,
    StActivate,
    StWaitRcd,
    StCmd,
    StWaitData,
    StPrecharge,
    StRefresh
  } state_e;

  function automatic logic [MAX_REQ-1:0] owner_onehot(logic [OWNER_W-1:0] id);
    return MAX_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/ddr_scheduler_if.sv
// Requester/datapath-facing bundle of the DDR scheduler; slave is the scheduler side.
interface ddr_scheduler_if
  import ddr_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]    req_i;
  logic [NREQ-1:0]    req_write_i;
  logic [NREQ-1:0]    gnt_o;
  logic [OWNER_W-1:0] usr_owner_o;
  logic               ctl_start_o;
  logic               ctl_block_o;
  logic               ctl_suspend_o;
  logic               ctl_read_o;
  logic               ctl_write_o;
  logic               dp_ready_i;
  logic               busy_o;
  logic               err_o;

  modport slave (
    input  req_i, req_write_i, dp_ready_i,
    output gnt_o, usr_owner_o, ctl_start_o, ctl_block_o, ctl_suspend_o,
    output ctl_read_o, ctl_write_o, busy_o, err_o
  );

  modport master (
    output req_i, req_write_i, dp_ready_i,
    input  gnt_o, usr_owner_o, ctl_start_o, ctl_block_o, ctl_suspend_o,
    input  ctl_read_o, ctl_write_o, busy_o, err_o
  );
endinterface

// File: rtl/ddr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping at NREQ.
module rr_arbiter
  import ddr_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [NREQ-1:0]    gnt,
  output logic [OWNER_W-1:0] id,
  output logic               valid
);
  logic [MAX_REQ-1:0] req_ext;
  logic [OWNER_W-1:0] idx;

  assign req_ext = MAX_REQ'(req);

  always_comb begin
    valid = 1'b0;
    id    = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = OWNER_W'((32'(ptr) + i) % NREQ);
      if (!valid && req_ext[idx]) begin
        valid = 1'b1;
        id    = idx;
      end
    end
    gnt = NREQ'(owner_onehot(id)) & {NREQ{valid}};
  end
endmodule

// File: rtl/ddr_scheduler.sv
// Round-robin DDR command sequencer with periodic refresh insertion.
// Optional WAIT_DATA watchdog enabled by defining SCHED_WATCHDOG_EN.
module ddr_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned T_RCD  = 2,
  parameter int unsigned T_RP   = 2,
  parameter int unsigned T_REFI = 780,
  parameter int unsigned T_RFC  = 8
) (
  input logic            clock_i,
  input logic            reset_i,
  ddr_scheduler_if.slave bus
);
  localparam int unsigned CntW  = 16;
  localparam int unsigned RefiW = $clog2(T_REFI + 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [RefiW-1:0]   refi_q, refi_d;
  logic               pend_q, pend_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               dir_q, dir_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    arb_gnt;
  logic [OWNER_W-1:0] arb_id;
  logic               arb_valid;
  logic [MAX_REQ-1:0] wr_ext;
  logic               refi_wrap, ref_due, wd_expire;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req_i),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .id    (arb_id),
    .valid (arb_valid)
  );

  assign wr_ext    = MAX_REQ'(bus.req_write_i);
  assign refi_wrap = (refi_q == RefiW'(T_REFI - 1));
  // The wrap cycle itself already counts as pending so refresh beats a same-cycle request.
  assign ref_due   = pend_q | refi_wrap;

`ifdef SCHED_WATCHDOG_EN
  logic [5:0] wd_q, wd_d;
  assign wd_expire = (state_q == StWaitData) && !bus.dp_ready_i && (wd_q == 6'(WD_LIMIT - 1));
  assign wd_d      = (state_q == StWaitData) ? wd_q + 6'd1 : 6'd0;
  always_ff @(posedge clock_i) begin
    if (reset_i) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    ptr_d   = ptr_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    gnt_d   = '0;
    refi_d  = refi_wrap ? '0 : refi_q + RefiW'(1);
    pend_d  = pend_q;
    if (refi_wrap) begin
      pend_d = 1'b1;
    end else if (state_q == StRefresh && cnt_q == CntW'(T_RFC - 1)) begin
      pend_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (ref_due) begin
          state_d = StRefresh;
        end else if (arb_valid) begin
          state_d = StActivate;
          owner_d = arb_id;
          dir_d   = wr_ext[arb_id];
          ptr_d   = OWNER_W'((32'(arb_id) + 1) % NREQ);
          gnt_d   = arb_gnt;
        end
      end
      StActivate: begin
        cnt_d   = '0;
        state_d = (T_RCD > 1) ? StWaitRcd : StCmd;
      end
      StWaitRcd: begin
        if (cnt_q == CntW'(T_RCD - 2)) begin
          state_d = StCmd;
          cnt_d   = '0;
        end
      end
      StCmd: begin
        cnt_d   = '0;
        state_d = StWaitData;
      end
      StWaitData: begin
        cnt_d = '0;
        if (bus.dp_ready_i || wd_expire) state_d = StPrecharge;
      end
      StPrecharge: begin
        if (cnt_q == CntW'(T_RP - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StRefresh: begin
        if (cnt_q == CntW'(T_RFC - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      refi_q  <= '0;
      pend_q  <= 1'b0;
      ptr_q   <= '0;
      owner_q <= '0;
      dir_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      refi_q  <= refi_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt_o         = gnt_q;
  assign bus.usr_owner_o   = owner_q;
  assign bus.ctl_start_o   = (state_q == StActivate);
  assign bus.ctl_block_o   = (state_q == StActivate) || (state_q == StWaitRcd) ||
                             (state_q == StCmd) || (state_q == StWaitData);
  assign bus.ctl_suspend_o = (state_q == StRefresh);
  assign bus.ctl_read_o    = (state_q == StCmd) && !dir_q;
  assign bus.ctl_write_o   = (state_q == StCmd) && dir_q;
  assign bus.busy_o        = (state_q != StIdle);
  assign bus.err_o         = wd_expire;
endmodule

// File: tb/tb_ddr_scheduler.sv
// Directed bench for ddr_scheduler: table-driven transaction traces plus round-robin,
// refresh collision, mid-transaction reset and watchdog sequences.
module tb_ddr_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ddr_scheduler_if #(.NREQ(4)) bus   ();
  ddr_scheduler_if #(.NREQ(4)) bus_r ();

  ddr_scheduler #(.NREQ(4), .T_RCD(2), .T_RP(2), .T_REFI(780), .T_RFC(8)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  ddr_scheduler #(.NREQ(4), .T_RCD(2), .T_RP(2), .T_REFI(20), .T_RFC(8)) dut_r (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus_r)
  );

  // {gnt[3:0], owner[1:0], start, block, suspend, read, write, busy, err}
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wr;
    logic        rdy;
    logic [12:0] exp;
  } vec_t;

  function automatic logic [12:0] e(logic [3:0] g, logic [1:0] o, logic s, logic b, logic su,
                                    logic r, logic w, logic bz);
    return {g, o, s, b, su, r, w, bz, 1'b0};
  endfunction

  function automatic logic [12:0] obs();
    return {bus.gnt_o, bus.usr_owner_o, bus.ctl_start_o, bus.ctl_block_o, bus.ctl_suspend_o,
            bus.ctl_read_o, bus.ctl_write_o, bus.busy_o, bus.err_o};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  vec_t vecs[17];

  initial begin
    bus.req_i         = '0;
    bus.req_write_i   = '0;
    bus.dp_ready_i    = 1'b0;
    bus_r.req_i       = '0;
    bus_r.req_write_i = '0;
    bus_r.dp_ready_i  = 1'b1;

    // Read by requester 1 (ready on third WAIT_DATA cycle), then write by requester 2
    // with ready already high in the CMD cycle.
    vecs[0]  = '{4'b0000, 4'b0000, 1'b0, e(4'b0000, 2'd0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{4'b0010, 4'b0000, 1'b0, e(4'b0010, 2'd1, 1, 1, 0, 0, 0, 1)};
    vecs[2]  = '{4'b0000, 4'b0000, 1'b0, e(4'b0000, 2'd1, 0, 1, 0, 0, 0, 1)};
    vecs[3]  = '{4'b0000, 4'b0000, 1'b0, e(4'b0000, 2'd1, 0, 1, 0, 1, 0, 1)};
    vecs[4]  = '{4'b0000, 4'b0000, 1'b0, e(4'b0000, 2'd1, 0, 1, 0, 0, 0, 1)};
    vecs[5]  = '{4'b0000, 4'b0000, 1'b0, e(4'b0000, 2'd1, 0, 1, 0, 0, 0, 1)};
    vecs[6]  = '{4'b0000, 4'b0000, 1'b0, e(4'b0000, 2'd1, 0, 1, 0, 0, 0, 1)};
    vecs[7]  = '{4'b0000, 4'b0000, 1'b1, e(4'b0000, 2'd1, 0, 0, 0, 0, 0, 1)};
    vecs[8]  = '{4'b0000, 4'b0000, 1'b0, e(4'b0000, 2'd1, 0, 0, 0, 0, 0, 1)};
    vecs[9]  = '{4'b0000, 4'b0000, 1'b0, e(4'b0000, 2'd1, 0, 0, 0, 0, 0, 0)};
    vecs[10] = '{4'b0100, 4'b0100, 1'b0, e(4'b0100, 2'd2, 1, 1, 0, 0, 0, 1)};
    vecs[11] = '{4'b0000, 4'b0000, 1'b0, e(4'b0000, 2'd2, 0, 1, 0, 0, 0, 1)};
    vecs[12] = '{4'b0000, 4'b0000, 1'b0, e(4'b0000, 2'd2, 0, 1, 0, 0, 1, 1)};
    vecs[13] = '{4'b0000, 4'b0000, 1'b1, e(4'b0000, 2'd2, 0, 1, 0, 0, 0, 1)};
    vecs[14] = '{4'b0000, 4'b0000, 1'b1, e(4'b0000, 2'd2, 0, 0, 0, 0, 0, 1)};
    vecs[15] = '{4'b0000, 4'b0000, 1'b0, e(4'b0000, 2'd2, 0, 0, 0, 0, 0, 1)};
    vecs[16] = '{4'b0000, 4'b0000, 1'b0, e(4'b0000, 2'd2, 0, 0, 0, 0, 0, 0)};

    do_reset();
    check("reset_outputs", 32'(obs()), 32'(e(4'b0000, 2'd0, 0, 0, 0, 0, 0, 0)));

    for (int i = 0; i < 17; i++) begin
      bus.req_i       = vecs[i].req;
      bus.req_write_i = vecs[i].wr;
      bus.dp_ready_i  = vecs[i].rdy;
      step();
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
    end

    // Round robin with 1011 held and ready always high: 0,1,3,0.
    begin
      logic [3:0] exp_g[4];
      logic [1:0] exp_o[4];
      exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      exp_o = '{2'd0, 2'd1, 2'd3, 2'd0};
      do_reset();
      bus.req_i      = 4'b1011;
      bus.dp_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
        int budget = 0;
        step();
        while (bus.gnt_o == 4'b0000 && budget < 20) begin
          step();
          budget++;
        end
        check($sformatf("rr_gnt%0d", k), 32'(bus.gnt_o), 32'(exp_g[k]));
        check($sformatf("rr_owner%0d", k), 32'(bus.usr_owner_o), 32'(exp_o[k]));
      end
      bus.req_i      = '0;
      bus.dp_ready_i = 1'b0;
    end

    // Refresh collision on the T_REFI=20 instance: request arrives in the wrap cycle.
    do_reset();
    for (int i = 0; i < 19; i++) step();
    check("refr_idle_before", 32'(bus_r.busy_o), 32'd0);
    bus_r.req_i = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("refr_susp%0d", i), 32'(bus_r.ctl_suspend_o), 32'd1);
      check($sformatf("refr_quiet%0d", i),
            32'({bus_r.gnt_o, bus_r.ctl_start_o, bus_r.ctl_read_o, bus_r.ctl_write_o,
                 bus_r.ctl_block_o}), 32'd0);
    end
    step();
    check("refr_end", 32'({bus_r.ctl_suspend_o, bus_r.ctl_start_o, bus_r.busy_o}), 32'd0);
    step();
    check("refr_then_act", 32'({bus_r.gnt_o, bus_r.ctl_start_o}), 32'b00011);
    bus_r.req_i = '0;

    // Reset while in WAIT_DATA, then the pointer must favour requester 0 again.
    do_reset();
    bus.req_i = 4'b0001;
    step();
    bus.req_i = '0;
    step();
    step();
    step();
    check("wd_state_block", 32'({bus.ctl_block_o, bus.busy_o}), 32'b11);
    rst = 1'b1;
    step();
    check("midreset_outputs", 32'(obs()), 32'd0);
    rst = 1'b0;
    bus.req_i = 4'b1001;
    step();
    check("midreset_ptr", 32'({bus.gnt_o, bus.usr_owner_o}), 32'({4'b0001, 2'd0}));
    bus.req_i = '0;

    // Ready never arrives.
    do_reset();
    bus.req_i = 4'b0001;
    step();
    bus.req_i = '0;
    step();
    step();
    check("wdog_cmd", 32'(bus.ctl_read_o), 32'd1);
`ifdef SCHED_WATCHDOG_EN
    begin
      int early = 0;
      for (int i = 1; i < 64; i++) begin
        step();
        if (bus.err_o) early++;
      end
      check("wdog_no_early_err", 32'(early), 32'd0);
      step();
      check("wdog_err_pulse", 32'({bus.err_o, bus.ctl_block_o}), 32'b11);
      step();
      check("wdog_precharge", 32'({bus.err_o, bus.ctl_block_o, bus.busy_o}), 32'b001);
      step();
      step();
      check("wdog_idle", 32'(bus.busy_o), 32'd0);
    end
`else
    for (int i = 0; i < 100; i++) step();
    check("wdog_hang", 32'({bus.busy_o, bus.ctl_block_o, bus.err_o}), 32'b110);
`endif
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
